sysid_regfile: RTL

SYSID_REGFILE -- requirements
Module: sysid_regfile

---
 rtl/sysid_regfile_if.sv | 23 ++
 rtl/sysid_regfile.sv | 103 ++++++++++
 2 files changed

// File: rtl/sysid_regfile_if.sv
// Memory-mapped slave bus for the system ID register file.
// The master drives one access per cycle; read data returns one cycle later.
interface sysid_regfile_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regfile.sv
// System ID / build timestamp / uptime register file with scratch registers.
// Reading UPTIME_LO snapshots the high word, so the LO-then-HI pair stays coherent.
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE    = 32'h5DE4_7F05,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 4,
    parameter int          ADDR_W      = 4
) (
    input  logic           clock,
    input  logic           reset,
    sysid_regfile_if.slave bus
);
    localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_HI   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(4);
    localparam int                SCR_BASE = 5;

    logic [63:0] uptime;
    logic [31:0] hi_snap;
    logic        ctrl_en;
    logic [31:0] scratch [NUM_SCRATCH];
    logic [31:0] rdata_q;
    logic        rdv_q;
    logic [31:0] rd_mux;

    logic ctrl_wr;
    logic clr;
    logic lo_rd;

    // EN and CLR both live in byte 0; with that byte disabled the write is a no-op.
    assign ctrl_wr = bus.write && (bus.address == A_CTRL) && bus.byteenable[0];
    assign clr     = ctrl_wr && bus.writedata[1];
    assign lo_rd   = bus.read && (bus.address == A_LO);

    always_ff @(posedge clock) begin
        if (reset) begin
            uptime  <= '0;
            ctrl_en <= 1'b1;
        end else begin
            if (clr)
                uptime <= '0;
            else if (ctrl_en)
                uptime <= uptime + 64'd1;
            if (ctrl_wr)
                ctrl_en <= bus.writedata[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            hi_snap <= '0;
        else if (lo_rd)
            hi_snap <= uptime[63:32];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch[i] <= '0;
        end else if (bus.write) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (bus.address == ADDR_W'(SCR_BASE + i)) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.byteenable[b])
                            scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_ID:    rd_mux = ID_VALUE;
            A_TS:    rd_mux = TIMESTAMP;
            A_LO:    rd_mux = uptime[31:0];
            A_HI:    rd_mux = hi_snap;
            A_CTRL:  rd_mux = {31'b0, ctrl_en};
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++)
                    if (bus.address == ADDR_W'(SCR_BASE + i))
                        rd_mux = scratch[i];
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            rdv_q <= bus.read;
            if (bus.read)
                rdata_q <= rd_mux;
        end
    end

    // Gated by reset so a reset arriving right after a read cancels its valid pulse.
    assign bus.readdata      = rdata_q;
    assign bus.readdatavalid = rdv_q && !reset;
endmodule
